ctrl_fsm: RTL

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/ctrl_decode.sv | 52 +++++
 rtl/ctrl_fsm.sv | 102 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: FSM states,
// opcode/funct fields, ALU operation codes and the reset IR value.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;

   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRX     = 3'b101;

   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SLL    = 4'd1;
   localparam logic [3:0] ALU_SLT    = 4'd2;
   localparam logic [3:0] ALU_SLTU   = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SRL    = 4'd5;
   localparam logic [3:0] ALU_OR     = 4'd6;
   localparam logic [3:0] ALU_AND    = 4'd7;
   localparam logic [3:0] ALU_SRA    = 4'd13;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // Writes to x0 are discarded, so the write enable depends on rd.
   function automatic logic rd_nonzero(input logic [31:0] ir);
      return |ir[11:7];
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Instruction decode: maps the latched IR fields to an ALU operation,
// flags loads and reports whether the encoding is one we execute.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_ctrl,
   output logic       is_load,
   output logic       legal
);

   // OP-IMM codes follow funct3 directly; only the right shift needs funct7
   // to pick between logical and arithmetic.
   always_comb begin
      alu_ctrl = ALU_ADD;
      is_load  = 1'b0;
      legal    = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            if (funct3 == F3_LW) begin
               is_load = 1'b1;
               legal   = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            case (funct3)
               F3_SLL: begin
                  alu_ctrl = ALU_SLL;
                  legal    = (funct7 == F7_ZERO);
               end
               F3_SRX: begin
                  if (funct7 == F7_ZERO) begin
                     alu_ctrl = ALU_SRL;
                     legal    = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     alu_ctrl = ALU_SRA;
                     legal    = 1'b1;
                  end
               end
               default: begin
                  alu_ctrl = {1'b0, funct3};
                  legal    = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetches, decodes and steps OP-IMM and
// LW instructions through EXEC/MEM/WB, keeps the PC, IR and retired count,
// and parks in TRAP on any unsupported encoding until reset.
//
//   state  | meaning
//   FETCH  | imem request outstanding, IR loads on imem_ready
//   DECODE | IR legality check, picks EXEC or TRAP
//   EXEC   | one cycle, alu_ctrl driven from IR
//   MEM    | LW data read outstanding, waits for dmem_ready
//   WB     | one cycle, register write, pc += 4, instret += 1
//   TRAP   | absorbing until reset, illegal asserted
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] instr,
   output logic        dmem_req,
   input  logic        dmem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] ir_out,
   output logic [3:0]  alu_ctrl,
   output logic        wb_sel,
   output logic        rf_we,
   output logic        illegal,
   output logic [31:0] instret
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] instret_q;

   logic [3:0]  dec_alu;
   logic        dec_is_load;
   logic        dec_legal;

   ctrl_decode u_decode (
      .opcode   (ir_q[6:0]),
      .funct3   (ir_q[14:12]),
      .funct7   (ir_q[31:25]),
      .alu_ctrl (dec_alu),
      .is_load  (dec_is_load),
      .legal    (dec_legal)
   );

   // State register; reset overrides any pending transition.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_FETCH;
      else     state <= state_nxt;
   end

   // Next-state selection; ready inputs only matter in their own states.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH:  if (imem_ready) state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = dec_legal ? ST_EXEC : ST_TRAP;
         ST_EXEC:   state_nxt = dec_is_load ? ST_MEM : ST_WB;
         ST_MEM:    if (dmem_ready) state_nxt = ST_WB;
         ST_WB:     state_nxt = ST_FETCH;
         ST_TRAP:   state_nxt = ST_TRAP;
         default:   state_nxt = ST_FETCH;
      endcase
   end

   // Datapath registers: IR capture on fetch, PC and retire count on WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         ir_q      <= INSTR_NOP;
         instret_q <= 32'd0;
      end else begin
         if (state == ST_FETCH && imem_ready) ir_q <= instr;
         if (state == ST_WB) begin
            pc_q      <= pc_q + 32'd4;
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   // Outputs decoded from state and IR; imem_req is also held off while
   // rst is asserted so no fetch is issued during the reset cycle.
   always_comb begin
      imem_req = (state == ST_FETCH) && !rst;
      dmem_req = (state == ST_MEM);
      wb_sel   = dec_is_load && (state == ST_MEM || state == ST_WB);
      rf_we    = (state == ST_WB) && rd_nonzero(ir_q);
      alu_ctrl = (state == ST_EXEC) ? dec_alu : ALU_ADD;
      illegal  = (state == ST_TRAP);
   end

   assign pc_out  = pc_q;
   assign ir_out  = ir_q;
   assign instret = instret_q;

endmodule
